// File: rtl/muxn_pkg.sv
// Shared types, default parameters and width helper for the muxn_scan block.
package muxn_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DWELL_W = 8;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn_next_ch.sv
// Rotating-priority finder: first enabled channel at or after i_start, wrapping to 0.
module muxn_next_ch
  import muxn_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  i_en,
  input  logic [SEL_W-1:0] i_start,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from far to near so the closest enabled channel wins.
  always_comb begin
    o_idx = i_start;
    w_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = SEL_W'((int'(i_start) + k) % N_CH);
      if (i_en[w_idx]) begin
        o_idx = w_idx;
      end
    end
  end

  assign o_any = |i_en;

endmodule

// File: rtl/muxn_scan.sv
// N-channel registered mux with valid/ready output stage and round-robin scan mode.
// Define MUXN_PARITY_EN to add the registered even-parity output y_par.
module muxn_scan
  import muxn_pkg::*;
#(
  parameter  int N_CH    = DEF_N_CH,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int DWELL_W = DEF_DWELL_W,
  localparam int SEL_W   = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [DATA_W-1:0]      y_data,
  output logic [SEL_W-1:0]       y_ch,
  output logic                   y_valid,
  input  logic                   y_ready
`ifdef MUXN_PARITY_EN
  ,
  output logic                   y_par
`endif
);

  logic               r_mode_q;
  logic [SEL_W-1:0]   r_cur_ch;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [DATA_W-1:0]  r_y_data;
  logic [SEL_W-1:0]   r_y_ch;
  logic               r_y_valid;

  mode_e              w_mode;
  logic               w_sel_ok;
  logic               w_any;
  logic               w_src_ok;
  logic               w_load;
  logic               w_last;
  logic               w_enter_scan;
  logic [SEL_W-1:0]   w_skip_idx;
  logic [SEL_W-1:0]   w_adv_start;
  logic [SEL_W-1:0]   w_adv_idx;
  logic [SEL_W-1:0]   w_src;
  logic [DWELL_W-1:0] w_eff_cnt;
  logic [DATA_W-1:0]  w_src_data;

  assign w_mode       = mode_e'(r_mode_q);
  assign w_sel_ok     = (32'(sel_in) < 32'(N_CH));
  assign w_enter_scan = mode && !r_mode_q;

  // Skip search: the current channel itself if enabled, else the next enabled one.
  muxn_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_skip (
    .i_en    (ch_en),
    .i_start (r_cur_ch),
    .o_idx   (w_skip_idx),
    .o_any   (w_any)
  );

  assign w_adv_start = (w_skip_idx == SEL_W'(N_CH - 1)) ? '0 : w_skip_idx + 1'b1;

  // Advance search starts one past the channel that supplies this beat.
  muxn_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_adv (
    .i_en    (ch_en),
    .i_start (w_adv_start),
    .o_idx   (w_adv_idx),
    .o_any   ()
  );

  always_comb begin
    w_src     = sel_in;
    w_src_ok  = w_sel_ok;
    w_eff_cnt = r_dwell_cnt;
    if (w_mode == MODE_SCAN) begin
      w_src    = w_skip_idx;
      w_src_ok = w_any;
      // A skipped-to channel starts its dwell afresh with this beat.
      if (w_skip_idx != r_cur_ch) begin
        w_eff_cnt = '0;
      end
    end
  end

  // >= so a dwell lowered below the running count still forces an advance.
  assign w_last = (w_eff_cnt >= dwell);
  assign w_load = (!r_y_valid || y_ready) && w_src_ok;

  always_comb begin
    w_src_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_src == SEL_W'(k)) begin
        w_src_data = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Scan sequencer state; frozen while in manual mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q    <= 1'b0;
      r_cur_ch    <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_mode_q <= mode;
      if (w_enter_scan) begin
        r_cur_ch    <= w_sel_ok ? sel_in : '0;
        r_dwell_cnt <= '0;
      end else if ((w_mode == MODE_SCAN) && w_load) begin
        if (w_last) begin
          r_cur_ch    <= w_adv_idx;
          r_dwell_cnt <= '0;
        end else begin
          r_cur_ch    <= w_skip_idx;
          r_dwell_cnt <= w_eff_cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage: load, drain, or hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_data  <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
    end else if (w_load) begin
      r_y_data  <= w_src_data;
      r_y_ch    <= w_src;
      r_y_valid <= 1'b1;
    end else if (y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign y_data  = r_y_data;
  assign y_ch    = r_y_ch;
  assign y_valid = r_y_valid;

`ifdef MUXN_PARITY_EN
  logic r_y_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_par <= 1'b0;
    end else if (w_load) begin
      r_y_par <= ^w_src_data;
    end
  end

  assign y_par = r_y_par;
`endif

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan: directed scenarios plus randomized traffic vs a reference model.
module tb_muxn_scan;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_en;
  logic            mode;
  logic [SW-1:0]   sel_in;
  logic [WW-1:0]   dwell;
  logic [DW-1:0]   y_data;
  logic [SW-1:0]   y_ch;
  logic            y_valid;
  logic            y_ready;
`ifdef MUXN_PARITY_EN
  logic            y_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int            m_mode_q;
  int            m_cur;
  int            m_cnt;
  int            m_ch;
  bit            m_valid;
  logic [DW-1:0] m_data;

  int exp_seq[13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

  muxn_scan #(
    .N_CH    (N),
    .DATA_W  (DW),
    .DWELL_W (WW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_data (ch_data),
    .ch_en   (ch_en),
    .mode    (mode),
    .sel_in  (sel_in),
    .dwell   (dwell),
    .y_data  (y_data),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready)
`ifdef MUXN_PARITY_EN
    ,
    .y_par   (y_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First enabled channel at or after s (wrapping), or -1 when none is enabled.
  function automatic int nxt(input int s);
    for (int k = 0; k < N; k++) begin
      if (ch_en[SW'((s + k) % N)]) return (s + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode_q = 0;
    m_cur    = 0;
    m_cnt    = 0;
    m_ch     = 0;
    m_valid  = 1'b0;
    m_data   = '0;
  endtask

  task automatic model_step();
    int src;
    bit ok;
    bit load;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode_q != 0) begin
      src = nxt(m_cur);
      ok  = (src >= 0);
    end else begin
      src = int'(sel_in);
      ok  = (src < N);
    end
    load = (!m_valid || y_ready) && ok;
    if (load) begin
      m_data  = DW'(ch_data >> (src * DW));
      m_ch    = src;
      m_valid = 1'b1;
    end else if (y_ready) begin
      m_valid = 1'b0;
    end
    if (mode && m_mode_q == 0) begin
      m_cur = (int'(sel_in) < N) ? int'(sel_in) : 0;
      m_cnt = 0;
    end else if (m_mode_q != 0 && load) begin
      if (src != m_cur) m_cnt = 0;
      if (m_cnt >= int'(dwell)) begin
        m_cur = nxt((src + 1) % N);
        m_cnt = 0;
      end else begin
        m_cur = src;
        m_cnt = m_cnt + 1;
      end
    end
    m_mode_q = int'(mode);
  endtask

  task automatic check_all();
    chk("y_valid", 32'(y_valid), 32'(m_valid));
    chk("y_data", 32'(y_data), 32'(m_data));
    chk("y_ch", 32'(y_ch), 32'(m_ch));
`ifdef MUXN_PARITY_EN
    chk("y_par", 32'(y_par), 32'(^m_data));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    ch_data = '0;
    ch_en   = '0;
    mode    = 1'b0;
    sel_in  = '0;
    dwell   = '0;
    y_ready = 1'b0;
    model_reset();

    repeat (2) tick();
    chk("rst_valid", 32'(y_valid), 32'd0);
    chk("rst_data", 32'(y_data), 32'd0);
    chk("rst_ch", 32'(y_ch), 32'd0);
    rst_n = 1'b1;

    // Manual pass-through
    ch_data = 32'hD3C2_B1A0;
    y_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      sel_in = SW'(k);
      tick();
      chk("man_data", 32'(y_data), 32'(8'hA0 + 8'(k) * 8'h11));
      chk("man_ch", 32'(y_ch), 32'(k));
    end

    // Back-pressure hold
    sel_in = 2'd2;
    tick();
    y_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ch_data = $urandom;
      tick();
      chk("bp_data", 32'(y_data), 32'h0000_00C2);
      chk("bp_ch", 32'(y_ch), 32'd2);
      chk("bp_valid", 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1;
    ch_data = 32'h4433_2211;
    tick();
    chk("bp_release", 32'(y_data), 32'h0000_0033);

    // Scan with dwell 2 from channel 1
    mode   = 1'b1;
    sel_in = 2'd1;
    dwell  = 8'd2;
    ch_en  = 4'b1111;
    tick();
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("scan_seq", 32'(y_ch), 32'(exp_seq[i]));
    end

    // Mask skip with dwell 0
    mode = 1'b0;
    tick();
    mode   = 1'b1;
    sel_in = 2'd1;
    ch_en  = 4'b1010;
    dwell  = 8'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mask_seq", 32'(y_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    ch_en = 4'b0000;
    tick();
    chk("mask_drain", 32'(y_valid), 32'd0);

    // Asynchronous reset in the middle of a scan on channel 2
    ch_en = 4'b1111;
    dwell = 8'd10;
    mode  = 1'b0;
    tick();
    mode   = 1'b1;
    sel_in = 2'd2;
    tick();
    tick();
    chk("pre_rst_ch", 32'(y_ch), 32'd2);
    chk("pre_rst_valid", 32'(y_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(y_valid), 32'd0);
    chk("arst_data", 32'(y_data), 32'd0);
    chk("arst_ch", 32'(y_ch), 32'd0);
    tick();
    rst_n  = 1'b1;
    mode   = 1'b1;
    sel_in = 2'd3;
    tick();
    chk("post_rst_ch", 32'(y_ch), 32'd3);
    chk("post_rst_valid", 32'(y_valid), 32'd1);
    tick();

`ifdef MUXN_PARITY_EN
    mode = 1'b0;
    tick();
    ch_data = 32'h0000_0307;
    sel_in  = 2'd0;
    tick();
    chk("par_07", 32'(y_par), 32'd1);
    sel_in = 2'd1;
    tick();
    chk("par_03", 32'(y_par), 32'd0);
`endif

    // Randomized traffic, mode toggling and mask/dwell changes
    for (int i = 0; i < 600; i++) begin
      ch_data = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
      sel_in  = SW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) ch_en = N'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) dwell = WW'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
